lpc_excitation_gen: RTL and testbench
=====================================

Name: lpc_excitation_gen

Overview:
LPC decoder excitation source, directly upstream of the LPC synthesis filter. It drives the filter's x/v input pair.
- Per frame it accepts voiced flag, pitch period and gain.
- On each sample strobe it emits one excitation sample: a gain-scaled pitch pulse train for voiced frames, or gain-scaled LFSR noise for unvoiced frames.
- A one-deep frame buffer lets frames run back-to-back with no sample gaps.

Parameters:
FRAME_LEN, 160, samples per frame (>=2)
PITCH_W, 8, pitch period width in samples
LFSR_SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
clk  in  1  clock
rst  in  1  reset
frame_valid  in  1  frame parameters valid
frame_ready  out  1  frame buffer can accept
frame_voiced  in  1  1=voiced, 0=unvoiced
frame_pitch  in  PITCH_W  pitch period in samples
frame_gain  in  16  signed Q15 gain
sample_tick  in  1  one-cycle sample-rate strobe
x  out  16  signed excitation sample
v  out  1  x valid, one cycle per sample
frame_done  out  1  pulse coincident with v of the last sample of a frame
underrun  out  1  pulse: sample_tick arrived with no active frame
busy  out  1  active frame in progress

Behaviour:
Interface
- Reset rst, synchronous, active-high; clock clk.
- Reset values: x=0, v=0, frame_done=0, underrun=0, busy=0, frame_ready=1.
- Reset also clears the shadow buffer, sets LFSR=LFSR_SEED, zeroes the sample and pitch counters, and sets state IDLE.
- Reset mid-frame discards the active frame and any buffered frame; no further v until a new frame is accepted.

Frame buffer
- frame_ready = !shadow_full (registered state, no combinational path from frame_valid).
- Handshake frame_valid&&frame_ready captures {voiced,pitch,gain} into shadow and sets shadow_full.
- Effective voiced = frame_voiced && (frame_pitch!=0); pitch 0 is treated as unvoiced.

State machine (IDLE, RUN)
- IDLE: if shadow_full, transfer shadow->active, clear shadow_full, go RUN next cycle; busy=1 in RUN. sample_tick in IDLE: v=0, underrun=1 for one cycle.
- RUN: each sample_tick produces one sample (registered; x/v valid the cycle after the tick) and increments sample_cnt (0..FRAME_LEN-1).
- Last sample (sample_cnt==FRAME_LEN-1): frame_done=1 with v, sample_cnt->0.
  - If shadow_full at that tick: transfer shadow->active in the same cycle and stay RUN, so the next tick belongs to the new frame.
  - Else go IDLE.
- Back-to-back ticks (every cycle) are supported.

Sample generation (per tick, RUN)
- Voiced: x = gain when pitch_cnt==0, else 0. pitch_cnt then becomes (pitch_cnt==pitch-1) ? 0 : pitch_cnt+1.
- Unvoiced: x = (signed(lfsr) * gain) >>> 15, using the low 16 bits of the 32-bit product, truncated (floor).
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shift-left with feedback into bit0.
  - Advances on every RUN tick regardless of voicing.
  - The output uses the pre-advance value.

Frame transitions (pitch_cnt)
- voiced->voiced: pitch_cnt continues (phase continuity); if pitch_cnt >= new pitch, it is set to 0.
- Any transition into voiced from unvoiced or IDLE: pitch_cnt=0, so the pulse lands on the first sample.

Decomposition:
- Shared package lpc_pkg: LFSR tap mask, default LFSR_SEED, state enum {IDLE,RUN}, and the frame parameter struct {voiced, pitch, gain}, also usable by the coefficient path.
- One natural sub-module: lpc_lfsr16 (clk, rst, advance, value). Everything else is inline.

Test Plan:
- FRAME_LEN=8, voiced pitch=4, gain=16'h2000, 8 ticks -> x = 2000,0,0,0,2000,0,0,0; frame_done on the 8th v; then IDLE, busy=0.
- Unvoiced, gain=16'h7FFF, first tick after reset -> x=16'hACE1 (-21279); following x values match a reference LFSR model for 16 samples.
- Two voiced frames pitch=3 preloaded (second accepted while the first runs, frame_ready low until transfer), FRAME_LEN=8 -> pulses at global samples 0,3,6,9,12,15; no gap in v between frames.
- sample_tick with no frame loaded -> underrun=1 for one cycle, v=0, x unchanged.
- Reset asserted at sample 3 of a frame with a buffered frame -> all outputs at reset values; later ticks give underrun; a new frame restarts with LFSR=ACE1.
- voiced pitch=0, gain=16'h7FFF -> output identical to the unvoiced case (noise, no pulses).

Source files
------------

// File: rtl/lpc_pkg.sv
// Shared types and constants for the LPC decoder: excitation state, frame parameters
// and the noise LFSR polynomial.
package lpc_pkg;

    // x^16 + x^14 + x^13 + x^11 + 1, taken from bits 15, 13, 12, 10 of a shift-left register
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;
    localparam int          PITCH_MAX_W       = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic                   voiced;
        logic [PITCH_MAX_W-1:0] pitch;
        logic [15:0]            gain;
    } frame_t;

endpackage

// File: rtl/lpc_excitation_gen_lfsr16.sv
// 16-bit Fibonacci LFSR noise source; shifts left with the feedback bit entering bit 0.
module lpc_lfsr16
    import lpc_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= SEED;
        end else if (advance) begin
            value <= {value[14:0], ^(value & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/lpc_excitation_gen.sv
// LPC excitation source: gain-scaled pitch pulse train or LFSR noise per frame, with a
// one-deep frame buffer so consecutive frames run without sample gaps.
module lpc_excitation_gen
    import lpc_pkg::*;
#(
    parameter int          FRAME_LEN = 160,
    parameter int          PITCH_W   = 8,
    parameter logic [15:0] LFSR_SEED = DEFAULT_LFSR_SEED
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_valid,
    output logic               frame_ready,
    input  logic               frame_voiced,
    input  logic [PITCH_W-1:0] frame_pitch,
    input  logic [15:0]        frame_gain,
    input  logic               sample_tick,
    output logic [15:0]        x,
    output logic               v,
    output logic               frame_done,
    output logic               underrun,
    output logic               busy
);

    localparam int               CNT_W    = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    state_t                 state, state_next;
    frame_t                 shadow, active, active_next;
    logic                   shadow_full, shadow_full_next;
    logic [CNT_W-1:0]       sample_cnt, sample_cnt_next;
    logic [PITCH_MAX_W-1:0] pitch_cnt, pitch_cnt_next, pitch_step;
    logic [15:0]            x_next, lfsr_value;
    logic                   run_tick, last_sample, capture, transfer;
    logic signed [31:0]     product;
    logic                   unused_product_bits;

    lpc_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (run_tick),
        .value   (lfsr_value)
    );

    assign frame_ready = !shadow_full;
    assign busy        = (state == RUN);

    always_comb begin
        run_tick    = (state == RUN) && sample_tick;
        last_sample = (sample_cnt == LAST_CNT);
        capture     = frame_valid && !shadow_full;
        transfer    = shadow_full && ((state == IDLE) || (run_tick && last_sample));
        product     = $signed({{16{lfsr_value[15]}}, lfsr_value})
                    * $signed({{16{active.gain[15]}}, active.gain});
        pitch_step  = (pitch_cnt == active.pitch - PITCH_MAX_W'(1)) ? '0
                                                                    : pitch_cnt + PITCH_MAX_W'(1);

        state_next       = state;
        active_next      = active;
        shadow_full_next = shadow_full;
        sample_cnt_next  = sample_cnt;
        pitch_cnt_next   = pitch_cnt;
        x_next           = x;

        if (capture) shadow_full_next = 1'b1;

        if (run_tick) begin
            // Noise path keeps bits [30:15] of the Q15 product: arithmetic shift, floor rounding
            x_next          = !active.voiced          ? product[30:15] :
                              (pitch_cnt == '0)       ? active.gain    : 16'h0000;
            sample_cnt_next = last_sample ? '0 : sample_cnt + CNT_W'(1);
            if (active.voiced) pitch_cnt_next = pitch_step;
        end

        case (state)
            IDLE:    if (shadow_full) state_next = RUN;
            RUN:     if (run_tick && last_sample && !shadow_full) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Pulse phase carries over only between two voiced frames; otherwise the pulse is on sample 0
        if (transfer) begin
            active_next      = shadow;
            shadow_full_next = 1'b0;
            if ((state == IDLE) || !active.voiced || !shadow.voiced || (pitch_step >= shadow.pitch))
                pitch_cnt_next = '0;
            else
                pitch_cnt_next = pitch_step;
        end
    end

    assign unused_product_bits = ^{product[31], product[14:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shadow      <= '0;
            shadow_full <= 1'b0;
            active      <= '0;
            sample_cnt  <= '0;
            pitch_cnt   <= '0;
            x           <= '0;
            v           <= 1'b0;
            frame_done  <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_next;
            shadow_full <= shadow_full_next;
            active      <= active_next;
            sample_cnt  <= sample_cnt_next;
            pitch_cnt   <= pitch_cnt_next;
            x           <= x_next;
            v           <= run_tick;
            frame_done  <= run_tick && last_sample;
            underrun    <= sample_tick && (state == IDLE);
            if (capture) begin
                shadow.voiced <= frame_voiced && (frame_pitch != '0);
                shadow.pitch  <= PITCH_MAX_W'(frame_pitch);
                shadow.gain   <= frame_gain;
            end
        end
    end

endmodule

// File: tb/tb_lpc_excitation_gen.sv
// Scoreboard bench for lpc_excitation_gen: stimulus queues expected samples, a monitor
// pops and compares them whenever v is presented.
module tb_lpc_excitation_gen;

    localparam int FL = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_valid = 1'b0;
    logic        frame_voiced = 1'b0;
    logic [7:0]  frame_pitch = 8'd0;
    logic [15:0] frame_gain = 16'h0000;
    logic        sample_tick = 1'b0;
    logic        frame_ready, v, frame_done, underrun, busy;
    logic [15:0] x;

    lpc_excitation_gen #(.FRAME_LEN(FL), .PITCH_W(8), .LFSR_SEED(16'hACE1)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_voiced (frame_voiced),
        .frame_pitch  (frame_pitch),
        .frame_gain   (frame_gain),
        .sample_tick  (sample_tick),
        .x            (x),
        .v            (v),
        .frame_done   (frame_done),
        .underrun     (underrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] x;
        logic        done;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] model_lfsr = 16'hACE1;
    logic [15:0] exp_last_x = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [15:0] noise(input logic [15:0] s, input logic [15:0] g);
        logic signed [31:0] p;
        p = $signed(s) * $signed(g);
        return p[30:15];
    endfunction

    always @(negedge clk) begin
        if (v) begin
            if (exp_q.size() == 0) begin
                check("unexpected_v", {31'd0, v}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("x", {16'd0, x}, {16'd0, e.x});
                check("frame_done", {31'd0, frame_done}, {31'd0, e.done});
                exp_last_x = e.x;
            end
        end else if (frame_done) begin
            check("stray_frame_done", {31'd0, frame_done}, 32'd0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic vo, input logic [7:0] p, input logic [15:0] g);
        int t;
        t = 0;
        while (!frame_ready && t < 100) begin
            cyc(1);
            t++;
        end
        check("ready_wait", {31'd0, frame_ready}, 32'd1);
        frame_valid  = 1'b1;
        frame_voiced = vo;
        frame_pitch  = p;
        frame_gain   = g;
        cyc(1);
        frame_valid  = 1'b0;
    endtask

    task automatic tick_exp(input logic [15:0] ex, input logic ed);
        exp_t e;
        e.x  = ex;
        e.done = ed;
        exp_q.push_back(e);
        model_lfsr  = lfsr_step(model_lfsr);
        sample_tick = 1'b1;
        cyc(1);
        sample_tick = 1'b0;
    endtask

    task automatic tick_pulses(input int n, input logic [31:0] mask, input logic [15:0] g, input int base);
        for (int i = 0; i < n; i++)
            tick_exp(mask[i] ? g : 16'h0000, ((base + i) % FL) == FL - 1);
    endtask

    task automatic tick_noise(input int n, input logic [15:0] g, input int base);
        for (int i = 0; i < n; i++)
            tick_exp(noise(model_lfsr, g), ((base + i) % FL) == FL - 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            cyc(1);
            t++;
        end
        check("drain_left", exp_q.size(), 32'd0);
    endtask

    task automatic tick_underrun();
        sample_tick = 1'b1;
        cyc(1);
        sample_tick = 1'b0;
        check("underrun_pulse", {31'd0, underrun}, 32'd1);
        check("underrun_v", {31'd0, v}, 32'd0);
        check("underrun_x_hold", {16'd0, x}, {16'd0, exp_last_x});
        cyc(1);
        check("underrun_one_cycle", {31'd0, underrun}, 32'd0);
    endtask

    task automatic check_reset_values();
        check("rst_x", {16'd0, x}, 32'd0);
        check("rst_v", {31'd0, v}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_ready", {31'd0, frame_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        cyc(2);
        rst = 1'b0;
        check_reset_values();

        // Unvoiced, two buffered frames: first samples are ACE1 and 59C2 for gain 7FFF
        send_frame(1'b0, 8'd5, 16'h7FFF);
        cyc(1);
        check("busy_run", {31'd0, busy}, 32'd1);
        send_frame(1'b0, 8'd5, 16'h7FFF);
        check("ready_low_buffered", {31'd0, frame_ready}, 32'd0);
        tick_exp(16'hACE1, 1'b0);
        tick_exp(16'h59C2, 1'b0);
        tick_noise(14, 16'h7FFF, 2);
        drain();
        check("idle_after_noise", {31'd0, busy}, 32'd0);

        tick_underrun();

        // Voiced pitch 4 with idle cycles between ticks
        send_frame(1'b1, 8'd4, 16'h2000);
        cyc(1);
        for (int i = 0; i < FL; i++) begin
            tick_exp((i == 0 || i == 4) ? 16'h2000 : 16'h0000, i == FL - 1);
            cyc(2);
        end
        drain();
        check("idle_after_voiced", {31'd0, busy}, 32'd0);

        // Two voiced pitch-3 frames preloaded, ticks every cycle: pulses 0,3,6,9,12,15
        send_frame(1'b1, 8'd3, 16'h4000);
        cyc(1);
        send_frame(1'b1, 8'd3, 16'h4000);
        check("ready_low_preload", {31'd0, frame_ready}, 32'd0);
        tick_pulses(16, 32'h9249, 16'h4000, 0);
        drain();
        check("ready_after_pair", {31'd0, frame_ready}, 32'd1);
        check("idle_after_pair", {31'd0, busy}, 32'd0);

        // Pitch 5 then pitch 3 (phase wraps to 0), voiced pitch 0 (noise), voiced pitch 3
        send_frame(1'b1, 8'd5, 16'h2000);
        cyc(1);
        send_frame(1'b1, 8'd3, 16'h2000);
        tick_pulses(9, 32'h4921, 16'h2000, 0);
        send_frame(1'b1, 8'd0, 16'h7FFF);
        tick_pulses(7, 32'h4921 >> 9, 16'h2000, 9);
        tick_noise(1, 16'h7FFF, 0);
        send_frame(1'b1, 8'd3, 16'h1234);
        tick_noise(7, 16'h7FFF, 1);
        tick_pulses(8, 32'h49, 16'h1234, 0);
        drain();
        check("idle_after_chain", {31'd0, busy}, 32'd0);

        // Reset mid-frame with a buffered frame
        send_frame(1'b1, 8'd4, 16'h2000);
        cyc(1);
        send_frame(1'b0, 8'd1, 16'h7FFF);
        tick_pulses(3, 32'h11, 16'h2000, 0);
        drain();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        model_lfsr = 16'hACE1;
        exp_last_x = 16'h0000;
        check_reset_values();
        cyc(3);
        check("no_restart_busy", {31'd0, busy}, 32'd0);
        tick_underrun();
        send_frame(1'b0, 8'd1, 16'h7FFF);
        cyc(1);
        tick_exp(16'hACE1, 1'b0);
        tick_exp(16'h59C2, 1'b0);
        tick_noise(6, 16'h7FFF, 2);
        drain();
        check("idle_at_end", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
